// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: fetch/decode/execute/mem/writeback FSM.
// Define CU_ADDI_EN to decode addi (opcode 001000) instead of trapping it.
module multicycle_cu #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_IDLE   = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

  state_t          st, nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      cause;
  logic [1:0]      aop;
  logic            waiting;
  logic            tmo;
  logic            is_mem, is_r, is_beq, is_j, is_addi;

  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_r   = (opcode == OP_R);
  assign is_beq = (opcode == OP_BEQ);
  assign is_j   = (opcode == OP_J);
`ifdef CU_ADDI_EN
  assign is_addi = (opcode == OPCODE_W'(6'b001000));
`else
  assign is_addi = 1'b0;
`endif

  assign waiting = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
  // mem_ready in the expiry cycle still completes the access
  assign tmo = (TIMEOUT > 0) && waiting && !mem_ready
            && (cnt == CW'(TIMEOUT));

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
                else if (tmo) nxt = S_TRAP;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  nxt = S_MEMADR;
          is_r:    nxt = S_EXEC;
          is_beq:  nxt = S_BRANCH;
          is_j:    nxt = S_JUMP;
          is_addi: nxt = S_ADDIEX;
          default: nxt = S_TRAP;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
                else if (tmo) nxt = S_TRAP;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
                else if (tmo) nxt = S_TRAP;
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= S_IDLE;
      cnt   <= '0;
      cause <= 2'b00;
    end else begin
      st <= nxt;
      if (nxt != st) cnt <= '0;
      else if (waiting && !mem_ready) cnt <= cnt + CW'(1);
      if (nxt == S_TRAP && st != S_TRAP)
        cause <= (st == S_DECODE) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aop           = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    trap          = 1'b0;
    unique case (st)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aop       = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aop           = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

  assign alu_op     = ALUOP_W'(aop);
  assign trap_cause = cause;
  assign state      = st;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu: instruction sequencing, waits,
// timeout and illegal-opcode traps, asynchronous reset abort.
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source, trap_cause;
  logic       instr_done, trap;
  logic [3:0] state;

  int checks = 0;
  int passes = 0;

  localparam logic [19:0] PW   = 20'h1 << 19;
  localparam logic [19:0] PWC  = 20'h1 << 18;
  localparam logic [19:0] IORD = 20'h1 << 17;
  localparam logic [19:0] MR   = 20'h1 << 16;
  localparam logic [19:0] MW   = 20'h1 << 15;
  localparam logic [19:0] IRW  = 20'h1 << 14;
  localparam logic [19:0] M2R  = 20'h1 << 13;
  localparam logic [19:0] RDST = 20'h1 << 12;
  localparam logic [19:0] RW   = 20'h1 << 11;
  localparam logic [19:0] SA   = 20'h1 << 10;
  localparam logic [19:0] SB1  = 20'h1 << 8;
  localparam logic [19:0] SB2  = 20'h2 << 8;
  localparam logic [19:0] SB3  = 20'h3 << 8;
  localparam logic [19:0] OP1  = 20'h1 << 6;
  localparam logic [19:0] OP2  = 20'h2 << 6;
  localparam logic [19:0] PS1  = 20'h1 << 4;
  localparam logic [19:0] PS2  = 20'h2 << 4;
  localparam logic [19:0] DONE = 20'h8;
  localparam logic [19:0] TRP  = 20'h4;
  localparam logic [19:0] C1   = 20'h1;
  localparam logic [19:0] C2   = 20'h2;

  localparam logic [19:0] F_RDY = PW | MR | IRW | SB1;

  logic [19:0] outs;
  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_source, instr_done, trap,
                 trap_cause};

  multicycle_cu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] es,
                     input logic [19:0] eo);
    checks++;
    assert ({state, outs} === {es, eo}) passes++;
    else $error("FAIL %s: state=%0d outs=%05h required state=%0d outs=%05h",
                tag, state, outs, es, eo);
  endtask

  task automatic reset_to_fetch(input logic rdy);
    rst_n = 1'b0;
    #1;
    chk("reset_idle", 4'd14, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = rdy;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    #12;
    chk("por_idle", 4'd14, 20'h0);
    rst_n = 1'b1;

    // R-type
    tick(); chk("r_fetch", 4'd0, F_RDY);
    tick(); chk("r_decode", 4'd1, SB3);
    tick(); chk("r_exec", 4'd6, SA | OP2);
    tick(); chk("r_aluwb", 4'd7, RW | RDST | DONE);
    tick(); chk("r_back", 4'd0, F_RDY);

    // lw with 3 wait cycles in MEMRD
    opcode = 6'b100011;
    tick(); chk("lw_decode", 4'd1, SB3);
    tick(); chk("lw_memadr", 4'd2, SA | SB2);
    mem_ready = 1'b0;
    tick(); chk("lw_memrd1", 4'd3, MR | IORD);
    tick(); chk("lw_memrd2", 4'd3, MR | IORD);
    tick(); chk("lw_memrd3", 4'd3, MR | IORD);
    tick(); mem_ready = 1'b1; #1;
    chk("lw_memrd4", 4'd3, MR | IORD);
    tick(); chk("lw_memwb", 4'd4, RW | M2R | DONE);
    tick(); chk("lw_back", 4'd0, F_RDY);

    // beq
    opcode = 6'b000100;
    tick(); chk("beq_decode", 4'd1, SB3);
    tick(); chk("beq_branch", 4'd8, SA | OP1 | PWC | PS1 | DONE);
    tick(); chk("beq_back", 4'd0, F_RDY);

    // j
    opcode = 6'b000010;
    tick();
    tick(); chk("j_jump", 4'd9, PW | PS2 | DONE);
    tick(); chk("j_back", 4'd0, F_RDY);

    // sw, zero-wait
    opcode = 6'b101011;
    tick();
    tick(); chk("sw_memadr", 4'd2, SA | SB2);
    tick(); chk("sw_memwr", 4'd5, MW | IORD | DONE);
    tick(); chk("sw_back", 4'd0, F_RDY);

    // sw aborted by reset during MEMWR
    tick();
    tick();
    mem_ready = 1'b0;
    tick(); chk("swr_memwr", 4'd5, MW | IORD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("swr_abort", 4'd14, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    tick(); chk("swr_resume", 4'd0, F_RDY);

    // illegal opcode
    opcode = 6'b111111;
    tick(); chk("ill_decode", 4'd1, SB3);
    tick(); chk("ill_trap", 4'd15, TRP | C1);
    tick(); chk("ill_sticky", 4'd15, TRP | C1);
    reset_to_fetch(1'b1);
    chk("ill_refetch", 4'd0, F_RDY);

    // addi
    opcode = 6'b001000;
    tick();
`ifdef CU_ADDI_EN
    tick(); chk("addi_ex", 4'd10, SA | SB2);
    tick(); chk("addi_wb", 4'd11, RW | DONE);
    tick(); chk("addi_back", 4'd0, F_RDY);
`else
    tick(); chk("addi_trap", 4'd15, TRP | C1);
`endif

    // fetch timeout: 16 FETCH cycles then TRAP cause 10
    reset_to_fetch(1'b0);
    chk("tmo_fetch1", 4'd0, MR);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_fetch16", 4'd0, MR);
    tick(); chk("tmo_trap", 4'd15, TRP | C2);
    mem_ready = 1'b1;
    tick();
    tick(); chk("tmo_sticky", 4'd15, TRP | C2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
